// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial pattern detector.
// Compares the most recent PATTERN_LEN accepted bits with a loaded pattern.
// Overlapping or restarting match modes are selectable.
// Matches are counted in a saturating counter.
// Optional feature macro: SEQ_DETECT_MASK_EN adds a care mask, loaded from cfg_mask.
module seq_detect_param #(
  parameter int unsigned PATTERN_LEN = 8,
  parameter int unsigned CNT_W       = 8,
  parameter logic [PATTERN_LEN-1:0] RST_PATTERN = 8'b1110_0101
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   din,
  input  logic                   din_valid,
  input  logic                   cfg_load,
  input  logic [PATTERN_LEN-1:0] cfg_pattern,
  input  logic [PATTERN_LEN-1:0] cfg_mask,
  input  logic                   overlap,
  input  logic                   cnt_clr,
  output logic                   flag,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   cnt_sat,
  output logic                   armed
);

  localparam int unsigned FW = $clog2(PATTERN_LEN + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PATTERN_LEN);
  localparam logic [FW-1:0] FILL_LAST = FW'(PATTERN_LEN - 1);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  logic [0:0]             state;
  logic [PATTERN_LEN-1:0] hist;
  logic [PATTERN_LEN-1:0] pattern;
  logic [PATTERN_LEN-1:0] mask;
  logic [FW-1:0]          fill;
  logic [PATTERN_LEN-1:0] nh;
  logic                   accept;
  logic                   match;

`ifdef SEQ_DETECT_MASK_EN
  logic [PATTERN_LEN-1:0] mask_q;

  // Care mask register, all positions compared after reset.
  always_ff @(posedge clk) begin
    if (!rst_n)        mask_q <= '1;
    else if (cfg_load) mask_q <= cfg_mask;
  end

  assign mask = mask_q;
`else
  logic cfg_mask_unused;
  assign cfg_mask_unused = ^cfg_mask;
  assign mask = '1;
`endif

  // Candidate history and match qualification; cfg_load discards the bit.
  always_comb begin
    nh     = {hist[PATTERN_LEN-2:0], din};
    accept = din_valid && !cfg_load;
    match  = accept && ((fill == FILL_LAST) || (state == ARMED)) &&
             (((nh ^ pattern) & mask) == '0);
  end

  // Pattern register, sampled only on cfg_load.
  always_ff @(posedge clk) begin
    if (!rst_n)        pattern <= RST_PATTERN;
    else if (cfg_load) pattern <= cfg_pattern;
  end

  // History shift, fill tracking and FILL/ARMED state.
  // A non-overlapping match restarts filling while still keeping the new bit in hist.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      state <= FILL;
    end else if (cfg_load) begin
      hist  <= '0;
      fill  <= '0;
      state <= FILL;
    end else if (accept) begin
      hist <= nh;
      if (match && !overlap) begin
        fill  <= '0;
        state <= FILL;
      end else begin
        if (fill != FILL_FULL) fill <= fill + 1'b1;
        if ((fill == FILL_LAST) || (state == ARMED)) state <= ARMED;
      end
    end
  end

  // Registered match pulse and saturating counter; cnt_clr beats a same-cycle match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag      <= 1'b0;
      match_cnt <= '0;
    end else begin
      flag <= match;
      if (cnt_clr)                match_cnt <= '0;
      else if (match && !cnt_sat) match_cnt <= match_cnt + 1'b1;
    end
  end

  // Status outputs.
  always_comb begin
    cnt_sat = (match_cnt == '1);
    armed   = (state == ARMED);
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (PATTERN_LEN=4, CNT_W=4).
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = '0;
  logic [3:0] cfg_mask = '1;
  logic       overlap = 1'b1;
  logic       cnt_clr = 1'b0;
  logic       flag;
  logic [3:0] match_cnt;
  logic       cnt_sat;
  logic       armed;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detect_param #(
    .PATTERN_LEN(4),
    .CNT_W(4),
    .RST_PATTERN(4'b1100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .overlap(overlap), .cnt_clr(cnt_clr), .flag(flag), .match_cnt(match_cnt),
    .cnt_sat(cnt_sat), .armed(armed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic idle_cycle(input logic b);
    @(negedge clk);
    din = b;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [3:0] p, input logic [3:0] m);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_pattern = p;
    cfg_mask = m;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    din_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] s;
    logic [3:0] ef;
    do_reset();
    n_checks++;
    if (flag !== 1'b0 || match_cnt !== 4'd0 || cnt_sat !== 1'b0 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: flag=%b cnt=%0d sat=%b armed=%b, required 0/0/0/0",
               flag, match_cnt, cnt_sat, armed);
    end
    repeat (3) idle_cycle(1'b1);
    n_checks++;
    if (flag !== 1'b0 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: flag=%b armed=%b, required 0/0", flag, armed);
    end
    overlap = 1'b1;
    s = 4'b1100;
    ef = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      send_bit(s[3-i]);
      n_checks++;
      if (flag !== ef[3-i]) begin
        n_fail++;
        $display("FAIL reset_pattern_flag bit%0d: flag=%b required %b", i + 1, flag, ef[3-i]);
      end
    end
    n_checks++;
    if (match_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_pattern_cnt: cnt=%0d required 1", match_cnt);
    end
  endtask

  task automatic run_stream(input logic ov, input logic [6:0] ef, input logic [6:0] ea,
                            input logic [3:0] ecnt, input string name);
    logic [6:0] s;
    do_reset();
    load_cfg(4'b1011, 4'b1111);
    overlap = ov;
    s = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      send_bit(s[6-i]);
      n_checks++;
      if (flag !== ef[6-i] || armed !== ea[6-i]) begin
        n_fail++;
        $display("FAIL %s bit%0d: flag=%b armed=%b required flag=%b armed=%b",
                 name, i + 1, flag, armed, ef[6-i], ea[6-i]);
      end
    end
    n_checks++;
    if (match_cnt !== ecnt) begin
      n_fail++;
      $display("FAIL %s_cnt: cnt=%0d required %0d", name, match_cnt, ecnt);
    end
  endtask

  task automatic test_overlap();
    run_stream(1'b1, 7'b0001001, 7'b0001111, 4'd2, "overlap");
  endtask

  task automatic test_no_overlap();
    run_stream(1'b0, 7'b0001000, 7'b0000000, 4'd1, "no_overlap");
  endtask

  task automatic test_valid_gap();
    do_reset();
    load_cfg(4'b1011, 4'b1111);
    overlap = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle(1'b1);
      n_checks++;
      if (flag !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_idle%0d: flag=%b required 0", i, flag);
      end
    end
    send_bit(1'b1);
    n_checks++;
    if (flag !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_bit3: flag=%b required 0", flag);
    end
    send_bit(1'b1);
    n_checks++;
    if (flag !== 1'b1 || match_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL gap_bit4: flag=%b cnt=%0d required 1/1", flag, match_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] first;
    logic [2:0] rep;
    int k;
    do_reset();
    load_cfg(4'b1011, 4'b1111);
    overlap = 1'b1;
    first = 4'b1011;
    rep = 3'b011;
    for (int i = 0; i < 4; i++) send_bit(first[3-i]);
    k = 1;
    n_checks++;
    if (flag !== 1'b1 || match_cnt !== 4'd1 || cnt_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_match1: flag=%b cnt=%0d sat=%b required 1/1/0", flag, match_cnt, cnt_sat);
    end
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 3; i++) send_bit(rep[2-i]);
      k++;
      n_checks++;
      if (flag !== 1'b1 || match_cnt !== 4'((k > 15) ? 15 : k) || cnt_sat !== (k >= 15)) begin
        n_fail++;
        $display("FAIL sat_match%0d: flag=%b cnt=%0d sat=%b required 1/%0d/%b",
                 k, flag, match_cnt, cnt_sat, (k > 15) ? 15 : k, (k >= 15));
      end
    end
    send_bit(1'b0);
    send_bit(1'b1);
    cnt_clr = 1'b1;
    send_bit(1'b1);
    cnt_clr = 1'b0;
    n_checks++;
    if (flag !== 1'b1 || match_cnt !== 4'd0 || cnt_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_with_match: flag=%b cnt=%0d sat=%b required 1/0/0", flag, match_cnt, cnt_sat);
    end
  endtask

  task automatic test_cfg_load_collision();
    do_reset();
    load_cfg(4'b1011, 4'b1111);
    overlap = 1'b1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_pattern = 4'b0000;
    cfg_mask = 4'b1111;
    din = 1'b1;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    din_valid = 1'b0;
    n_checks++;
    if (flag !== 1'b0 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL load_collision: flag=%b armed=%b required 0/0", flag, armed);
    end
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b0);
      n_checks++;
      if (flag !== (i == 3)) begin
        n_fail++;
        $display("FAIL load_refill bit%0d: flag=%b required %b", i + 1, flag, (i == 3));
      end
    end
`ifdef SEQ_DETECT_MASK_EN
    load_cfg(4'b1001, 4'b1001);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    n_checks++;
    if (flag !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_prefix: flag=%b required 0", flag);
    end
    send_bit(1'b1);
    n_checks++;
    if (flag !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_match: flag=%b required 1", flag);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_valid_gap();
    test_saturation();
    test_cfg_load_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
